meter_time_adder: RTL and testbench

//  Owns the parking-meter time register and is the write side of the time path. Edge-detects coin/reset

---
 rtl/meter_time_adder.sv | 148 ++++++++++++++
 tb/tb_meter_time_adder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/meter_time_adder.sv
// Parking-meter time register: synchronizes coin/reset buttons, adds or loads seconds with saturation,
// and reloads from the decrementer on each tick. Optional press lockout is enabled by `define LOCKOUT_EN.
module meter_time_adder #(
  parameter int WIDTH       = 16,
  parameter int MAX_TIME    = 9999,
  parameter int AMT0        = 50,
  parameter int AMT1        = 150,
  parameter int AMT2        = 200,
  parameter int AMT3        = 500,
  parameter int RST_A       = 10,
  parameter int RST_B       = 205,
  parameter int LOCK_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_1s,
  input  logic [WIDTH-1:0] dec_value,
  input  logic [3:0]       btn_add,
  input  logic             btn_rst_a,
  input  logic             btn_rst_b,
  output logic [WIDTH-1:0] adder_value,
  output logic             add_ack,
  output logic             saturated,
  output logic             expired
);

  typedef enum logic [1:0] {IDLE, APPLY, HOLD} state_t;

  localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX_TIME);
  localparam logic [WIDTH:0]   MAX_W   = (WIDTH+1)'(MAX_TIME);
  localparam logic [2:0]       OP_RSTA = 3'd4;
  localparam logic [2:0]       OP_RSTB = 3'd5;

  state_t           state_reg;
  logic [5:0]       btn_all;
  logic [5:0]       sync1_reg, sync2_reg, sync3_reg;
  logic [5:0]       rise;
  logic [2:0]       op_reg, op_next;
  logic [WIDTH-1:0] adder_value_reg, value_next;
  logic [WIDTH-1:0] dec_clamped, base;
  logic [WIDTH:0]   amt, sum;
  logic             add_ack_reg, saturated_reg, expired_reg;

  // Bit order matches priority: highest index wins.
  assign btn_all = {btn_rst_b, btn_rst_a, btn_add};
  assign rise    = sync2_reg & ~sync3_reg;

  always_comb begin
    op_next = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (rise[i]) op_next = 3'(i);
    end
  end

  always_comb begin
    case (op_reg)
      3'd0:    amt = (WIDTH+1)'(AMT0);
      3'd1:    amt = (WIDTH+1)'(AMT1);
      3'd2:    amt = (WIDTH+1)'(AMT2);
      default: amt = (WIDTH+1)'(AMT3);
    endcase
  end

  assign dec_clamped = (dec_value > MAX_V) ? MAX_V : dec_value;
  // A tick landing on the APPLY cycle is folded in by adding to the decremented value.
  assign base        = tick_1s ? dec_clamped : adder_value_reg;
  assign sum         = {1'b0, base} + amt;

  always_comb begin
    value_next = adder_value_reg;
    if (state_reg == APPLY) begin
      if (op_reg == OP_RSTB)      value_next = WIDTH'(RST_B);
      else if (op_reg == OP_RSTA) value_next = WIDTH'(RST_A);
      else if (sum > MAX_W)       value_next = MAX_V;
      else                        value_next = sum[WIDTH-1:0];
    end else if (tick_1s) begin
      value_next = dec_clamped;
    end
  end

`ifdef LOCKOUT_EN
  localparam int CNT_W = $clog2(LOCK_CYCLES + 1);
  logic [CNT_W-1:0] lock_cnt_reg;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      sync1_reg       <= '0;
      sync2_reg       <= '0;
      sync3_reg       <= '0;
      op_reg          <= '0;
      adder_value_reg <= '0;
      add_ack_reg     <= 1'b0;
      saturated_reg   <= 1'b0;
      expired_reg     <= 1'b1;
`ifdef LOCKOUT_EN
      lock_cnt_reg    <= '0;
`endif
    end else begin
      sync1_reg       <= btn_all;
      sync2_reg       <= sync1_reg;
      sync3_reg       <= sync2_reg;
      adder_value_reg <= value_next;
      saturated_reg   <= (value_next == MAX_V);
      expired_reg     <= (value_next == '0);
      add_ack_reg     <= (state_reg == APPLY);
      case (state_reg)
        IDLE: begin
          if (|rise) begin
            op_reg    <= op_next;
            state_reg <= APPLY;
          end
        end
        APPLY: begin
`ifdef LOCKOUT_EN
          lock_cnt_reg <= '0;
          state_reg    <= HOLD;
`else
          state_reg    <= IDLE;
`endif
        end
        HOLD: begin
`ifdef LOCKOUT_EN
          // Any synced button high restarts the quiet-time count.
          if (|sync2_reg) begin
            lock_cnt_reg <= '0;
          end else if (lock_cnt_reg == CNT_W'(LOCK_CYCLES - 1)) begin
            lock_cnt_reg <= '0;
            state_reg    <= IDLE;
          end else begin
            lock_cnt_reg <= lock_cnt_reg + 1'b1;
          end
`else
          state_reg <= IDLE;
`endif
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign adder_value = adder_value_reg;
  assign add_ack     = add_ack_reg;
  assign saturated   = saturated_reg;
  assign expired     = expired_reg;

endmodule

// File: tb/tb_meter_time_adder.sv
// Directed testbench for meter_time_adder; expectations follow LOCKOUT_EN when it is defined.
module tb_meter_time_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tick_1s;
  logic [15:0] dec_value;
  logic [3:0]  btn_add;
  logic        btn_rst_a;
  logic        btn_rst_b;
  logic [15:0] adder_value;
  logic        add_ack;
  logic        saturated;
  logic        expired;

  int checks = 0;
  int errors = 0;
  int ack_count = 0;

`ifdef LOCKOUT_EN
  localparam int BOUNCE_ACKS  = 1;
  localparam int BOUNCE_VAL   = 50;
  localparam int REPRESS_ACKS = 2;
  localparam int REPRESS_VAL  = 100;
`else
  localparam int BOUNCE_ACKS  = 2;
  localparam int BOUNCE_VAL   = 100;
  localparam int REPRESS_ACKS = 3;
  localparam int REPRESS_VAL  = 150;
`endif

  meter_time_adder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick_1s     (tick_1s),
    .dec_value   (dec_value),
    .btn_add     (btn_add),
    .btn_rst_a   (btn_rst_a),
    .btn_rst_b   (btn_rst_b),
    .adder_value (adder_value),
    .add_ack     (add_ack),
    .saturated   (saturated),
    .expired     (expired)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (add_ack === 1'b1) ack_count++;

  // Every stimulus step ends 1 time unit after a rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_add(input logic [3:0] bits, input int n);
    btn_add = bits;
    step(n);
  endtask

  task automatic load_value(input logic [15:0] v);
    dec_value = v;
    tick_1s   = 1'b1;
    step(1);
    tick_1s   = 1'b0;
  endtask

  task automatic quiet(input int n);
    btn_add = 4'b0; btn_rst_a = 1'b0; btn_rst_b = 1'b0;
    step(n);
  endtask

  task automatic test_reset;
    checks++; if (adder_value !== 16'd0) begin errors++; $display("FAIL reset_value: got %0d want 0", adder_value); end
    checks++; if (add_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", add_ack); end
    checks++; if (saturated !== 1'b0) begin errors++; $display("FAIL reset_sat: got %b want 0", saturated); end
    checks++; if (expired !== 1'b1) begin errors++; $display("FAIL reset_expired: got %b want 1", expired); end
    $display("test_reset: value=%0d expired=%b", adder_value, expired);
  endtask

  task automatic test_add_latency;
    int a0;
    a0 = ack_count;
    btn_add = 4'b0010;
    step(3);
    checks++; if (add_ack !== 1'b0 || adder_value !== 16'd0) begin errors++; $display("FAIL latency_early: got ack=%b value=%0d want ack=0 value=0", add_ack, adder_value); end
    step(1);
    checks++; if (adder_value !== 16'd150) begin errors++; $display("FAIL latency_value: got %0d want 150", adder_value); end
    checks++; if (add_ack !== 1'b1) begin errors++; $display("FAIL latency_ack: got %b want 1", add_ack); end
    checks++; if (expired !== 1'b0) begin errors++; $display("FAIL latency_expired: got %b want 0", expired); end
    step(1);
    checks++; if (add_ack !== 1'b0) begin errors++; $display("FAIL latency_ack_width: got %b want 0", add_ack); end
    step(3);
    quiet(10);
    checks++; if (ack_count - a0 !== 1) begin errors++; $display("FAIL latency_ack_count: got %0d want 1", ack_count - a0); end
    $display("test_add_latency: value=%0d", adder_value);
  endtask

  task automatic test_saturation;
    load_value(16'd9900);
    checks++; if (adder_value !== 16'd9900 || saturated !== 1'b0) begin errors++; $display("FAIL sat_load: got value=%0d sat=%b want 9900 sat=0", adder_value, saturated); end
    drive_add(4'b1000, 4);
    quiet(10);
    checks++; if (adder_value !== 16'd9999 || saturated !== 1'b1) begin errors++; $display("FAIL sat_add3: got value=%0d sat=%b want 9999 sat=1", adder_value, saturated); end
    drive_add(4'b0001, 4);
    quiet(10);
    checks++; if (adder_value !== 16'd9999 || saturated !== 1'b1) begin errors++; $display("FAIL sat_hold: got value=%0d sat=%b want 9999 sat=1", adder_value, saturated); end
    $display("test_saturation: value=%0d saturated=%b", adder_value, saturated);
  endtask

  task automatic test_clamp;
    load_value(16'd12000);
    checks++; if (adder_value !== 16'd9999 || saturated !== 1'b1) begin errors++; $display("FAIL clamp_dec: got value=%0d sat=%b want 9999 sat=1", adder_value, saturated); end
    load_value(16'd0);
    checks++; if (adder_value !== 16'd0 || expired !== 1'b1 || saturated !== 1'b0) begin errors++; $display("FAIL tick_zero: got value=%0d exp=%b sat=%b want 0 exp=1 sat=0", adder_value, expired, saturated); end
    $display("test_clamp: value=%0d expired=%b", adder_value, expired);
  endtask

  task automatic test_tick_apply;
    load_value(16'd300);
    btn_add = 4'b0001;
    step(3);
    tick_1s = 1'b1; dec_value = 16'd299;
    step(1);
    tick_1s = 1'b0;
    checks++; if (adder_value !== 16'd349) begin errors++; $display("FAIL tick_apply: got %0d want 349", adder_value); end
    quiet(10);
    $display("test_tick_apply: value=%0d", adder_value);
  endtask

  task automatic test_priority;
    int a0;
    load_value(16'd1000);
    a0 = ack_count;
    btn_rst_b = 1'b1; btn_add = 4'b1000;
    step(4);
    quiet(10);
    checks++; if (adder_value !== 16'd205) begin errors++; $display("FAIL prio_rstb: got %0d want 205", adder_value); end
    checks++; if (ack_count - a0 !== 1) begin errors++; $display("FAIL prio_acks: got %0d want 1", ack_count - a0); end
    load_value(16'd500);
    btn_rst_a = 1'b1;
    step(4);
    quiet(10);
    checks++; if (adder_value !== 16'd10) begin errors++; $display("FAIL prio_rsta: got %0d want 10", adder_value); end
    $display("test_priority: value=%0d", adder_value);
  endtask

  task automatic test_async_reset;
    int a0;
    load_value(16'd9999);
    a0 = ack_count;
    btn_add = 4'b0010;
    step(3);
    rst_n = 1'b0;
    #1;
    checks++; if (adder_value !== 16'd0 || add_ack !== 1'b0) begin errors++; $display("FAIL async_value: got value=%0d ack=%b want 0 ack=0", adder_value, add_ack); end
    checks++; if (saturated !== 1'b0 || expired !== 1'b1) begin errors++; $display("FAIL async_flags: got sat=%b exp=%b want sat=0 exp=1", saturated, expired); end
    btn_add = 4'b0;
    step(2);
    rst_n = 1'b1;
    quiet(10);
    checks++; if (adder_value !== 16'd0 || ack_count != a0) begin errors++; $display("FAIL async_discard: got value=%0d acks=%0d want 0 acks=0", adder_value, ack_count - a0); end
    $display("test_async_reset: value=%0d", adder_value);
  endtask

  task automatic test_bounce;
    int a0;
    load_value(16'd0);
    a0 = ack_count;
    drive_add(4'b0001, 2);
    drive_add(4'b0000, 2);
    drive_add(4'b0001, 20);
    quiet(12);
    checks++; if (ack_count - a0 !== BOUNCE_ACKS) begin errors++; $display("FAIL bounce_acks: got %0d want %0d", ack_count - a0, BOUNCE_ACKS); end
    checks++; if (adder_value !== 16'(BOUNCE_VAL)) begin errors++; $display("FAIL bounce_value: got %0d want %0d", adder_value, BOUNCE_VAL); end
    $display("test_bounce: acks=%0d value=%0d", ack_count - a0, adder_value);
  endtask

  task automatic test_repress;
    int a0;
    load_value(16'd0);
    a0 = ack_count;
    drive_add(4'b0001, 6);
    drive_add(4'b0000, 1);
    drive_add(4'b0001, 3);
    drive_add(4'b0000, 10);
    drive_add(4'b0001, 3);
    quiet(12);
    checks++; if (ack_count - a0 !== REPRESS_ACKS) begin errors++; $display("FAIL repress_acks: got %0d want %0d", ack_count - a0, REPRESS_ACKS); end
    checks++; if (adder_value !== 16'(REPRESS_VAL)) begin errors++; $display("FAIL repress_value: got %0d want %0d", adder_value, REPRESS_VAL); end
    $display("test_repress: acks=%0d value=%0d", ack_count - a0, adder_value);
  endtask

  initial begin
    rst_n = 1'b0; tick_1s = 1'b0; dec_value = 16'd0;
    btn_add = 4'b0; btn_rst_a = 1'b0; btn_rst_b = 1'b0;
    step(2);
    test_reset();
    rst_n = 1'b1;
    step(2);
    test_add_latency();
    test_saturation();
    test_clamp();
    test_tick_apply();
    test_priority();
    test_async_reset();
    test_bounce();
    test_repress();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
